// File: rtl/xbar_pkg.sv
// Shared cross-bar types and constants: request payload layout and the
// HTU write-buffer ID encoding.
package xbar_pkg;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int ENTRY_W   = 3;
  localparam int WBUF_ID_W = 8;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int OP_W      = 2;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [ENTRY_W-1:0] entry_id;
  } xbar_req_t;

  function automatic logic [WBUF_ID_W-1:0] make_wbuffer_id(
    input logic [CH_W-1:0]    ch,
    input logic [ENTRY_W-1:0] entry
  );
    return {{(WBUF_ID_W - CH_W - ENTRY_W){1'b0}}, ch, entry};
  endfunction

endpackage

// File: rtl/xbar_rr_arb4.sv
// Combinational 4-way round-robin picker: first requester at or above ptr
// (mod 4) wins; gnt is gated by en, gnt_idx is meaningful only when gnt != 0.
module xbar_rr_arb4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic       en_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = idx;
      end
    end
    if (en_i && found) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/xbar_bank_arbiter.sv
// Per-bank arbiter: round-robin selects one channel buffer head, holds it in
// an output register until the HTU accepts, and caps in-flight requests.
module xbar_bank_arbiter
  import xbar_pkg::*;
#(
  parameter int ENTRY_W         = 3,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BANK_ID         = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               ch_valid_i,
  output logic [NUM_CH-1:0]               ch_allowIn_o,
  input  logic [NUM_CH-1:0][OP_W-1:0]     ch_op_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0][ENTRY_W-1:0]  ch_entry_id_i,
  output logic                            htu_valid_o,
  input  logic                            htu_allowIn_i,
  output logic [CH_W-1:0]                 htu_ch_id_o,
  output logic [OP_W-1:0]                 htu_opcode_o,
  output logic [ADDR_W-1:0]               htu_addr_o,
  output logic [DATA_W-1:0]               htu_data_o,
  output logic [WBUF_ID_W-1:0]            htu_wbuffer_id_o,
  input  logic                            htu_done_i,
  output logic [3:0]                      outstanding_o,
  output logic                            err_o
);

  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [1:0] BANK_SEL = 2'(BANK_ID);

  logic              vld_q, vld_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  xbar_req_t         req_q, req_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              reg_free;
  logic              can_issue;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              grant;
  logic              done_err;
  logic              bank_err;

  // Credit check uses the registered count only, so a done pulse never frees
  // a slot in the same cycle.
  assign reg_free  = !vld_q || htu_allowIn_i;
  assign can_issue = reg_free && (cnt_q < MAX_CNT) && !rst;

  xbar_rr_arb4 u_arb (
    .req_i     (ch_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (can_issue),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign grant        = |gnt;
  assign ch_allowIn_o = gnt;
  assign done_err     = htu_done_i && (cnt_q == 4'd0);
  assign bank_err     = grant && (ch_addr_i[gnt_idx][5:4] != BANK_SEL);

  always_comb begin
    vld_d = vld_q;
    ch_d  = ch_q;
    req_d = req_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q || done_err || bank_err;

    if (grant) begin
      vld_d          = 1'b1;
      ch_d           = gnt_idx;
      ptr_d          = gnt_idx + 2'd1;
      req_d.op       = ch_op_i[gnt_idx];
      req_d.addr     = {ch_addr_i[gnt_idx][ADDR_W-1:4], 4'b0000};
      req_d.data     = ch_data_i[gnt_idx];
      req_d.entry_id = xbar_pkg::ENTRY_W'(ch_entry_id_i[gnt_idx]);
    end else if (htu_allowIn_i) begin
      vld_d = 1'b0;
    end

    // A stray done at zero is flagged and otherwise ignored.
    case ({grant, htu_done_i && !done_err})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      ch_q  <= '0;
      req_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      ch_q  <= ch_d;
      req_q <= req_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign htu_valid_o      = vld_q;
  assign htu_ch_id_o      = ch_q;
  assign htu_opcode_o     = req_q.op;
  assign htu_addr_o       = req_q.addr;
  assign htu_data_o       = req_q.data;
  assign htu_wbuffer_id_o = make_wbuffer_id(ch_q, req_q.entry_id);
  assign outstanding_o    = cnt_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Directed bench for xbar_bank_arbiter: one task per scenario, inline checks.
module tb_xbar_bank_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         ch_valid;
  logic [3:0]         ch_allowIn;
  logic [3:0][1:0]    ch_op;
  logic [3:0][31:0]   ch_addr;
  logic [3:0][127:0]  ch_data;
  logic [3:0][2:0]    ch_entry;
  logic               htu_valid;
  logic               htu_allowIn;
  logic [1:0]         htu_ch_id;
  logic [1:0]         htu_opcode;
  logic [31:0]        htu_addr;
  logic [127:0]       htu_data;
  logic [7:0]         htu_wbuf;
  logic               htu_done;
  logic [3:0]         outstanding;
  logic               err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xbar_bank_arbiter #(.ENTRY_W(3), .MAX_OUTSTANDING(8), .BANK_ID(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .ch_valid_i       (ch_valid),
    .ch_allowIn_o     (ch_allowIn),
    .ch_op_i          (ch_op),
    .ch_addr_i        (ch_addr),
    .ch_data_i        (ch_data),
    .ch_entry_id_i    (ch_entry),
    .htu_valid_o      (htu_valid),
    .htu_allowIn_i    (htu_allowIn),
    .htu_ch_id_o      (htu_ch_id),
    .htu_opcode_o     (htu_opcode),
    .htu_addr_o       (htu_addr),
    .htu_data_o       (htu_data),
    .htu_wbuffer_id_o (htu_wbuf),
    .htu_done_i       (htu_done),
    .outstanding_o    (outstanding),
    .err_o            (err)
  );

  task automatic clear_inputs();
    ch_valid    = '0;
    ch_op       = '0;
    ch_addr     = '0;
    ch_data     = '0;
    ch_entry    = '0;
    htu_allowIn = 1'b1;
    htu_done    = 1'b0;
  endtask

  // Advance past the next rising edge; inputs may be changed right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ch_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (ch_allowIn !== 4'b0000 || htu_valid !== 1'b0 || outstanding !== 4'd0 ||
        err !== 1'b0 || htu_addr !== 32'd0 || htu_wbuf !== 8'd0) begin
      fails++;
      $display("FAIL reset: allowIn=%b valid=%b outst=%0d err=%b addr=%h wbuf=%h (need 0000 0 0 0 0 0)",
               ch_allowIn, htu_valid, outstanding, err, htu_addr, htu_wbuf);
    end
    $display("[TB] reset: allowIn=%b valid=%b outst=%0d", ch_allowIn, htu_valid, outstanding);
    rst = 1'b0;
    ch_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    ch_valid[2] = 1'b1;
    ch_op[2]    = 2'd1;
    ch_addr[2]  = 32'h0000_1234;
    ch_data[2]  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    ch_entry[2] = 3'd5;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant: allowIn=%b need 0100", ch_allowIn);
    end
    tick();
    ch_valid = '0;
    #1;
    tests++;
    // addr[5:4] of 0x1234 is 2'b11, which does not match bank 0
    if (htu_valid !== 1'b1 || htu_ch_id !== 2'd2 || htu_opcode !== 2'd1 ||
        htu_addr !== 32'h0000_1230 || htu_wbuf !== 8'h15 || outstanding !== 4'd1 ||
        htu_data !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0 || err !== 1'b1) begin
      fails++;
      $display("FAIL single_out: valid=%b ch=%0d op=%0d addr=%h wbuf=%h outst=%0d err=%b (need 1 2 1 00001230 15 1 1)",
               htu_valid, htu_ch_id, htu_opcode, htu_addr, htu_wbuf, outstanding, err);
    end
    $display("[TB] single: ch=%0d addr=%h wbuf=%h outst=%0d", htu_ch_id, htu_addr, htu_wbuf, outstanding);
  endtask

  task automatic test_fairness();
    int cnt[4];
    logic [3:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    ch_valid = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      htu_done = (i > 0);
      #1;
      exp_gnt = 4'b0001 << (i % 4);
      tests++;
      if (ch_allowIn !== exp_gnt) begin
        fails++;
        $display("FAIL fair_order[%0d]: allowIn=%b need %b", i, ch_allowIn, exp_gnt);
      end
      if (i > 0) begin
        tests++;
        if (htu_valid !== 1'b1 || htu_ch_id !== 2'((i - 1) % 4) || outstanding !== 4'd1) begin
          fails++;
          $display("FAIL fair_out[%0d]: valid=%b ch=%0d outst=%0d need 1 %0d 1",
                   i, htu_valid, htu_ch_id, outstanding, (i - 1) % 4);
        end
      end
      for (int c = 0; c < 4; c++) if (ch_allowIn[c]) cnt[c]++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (cnt[c] != 25) begin
        fails++;
        $display("FAIL fair_count ch%0d: got %0d need 25", c, cnt[c]);
      end
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL fair_err: err=%b need 0", err);
    end
    $display("[TB] fairness: counts %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
    ch_valid = '0;
    htu_done = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_valid    = 4'b0011;
    ch_addr[0]  = 32'h0000_0A00;
    ch_addr[1]  = 32'h0000_0B0F;
    ch_entry[0] = 3'd2;
    ch_entry[1] = 3'd6;
    htu_allowIn = 1'b0;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0001) begin
      fails++;
      $display("FAIL bp_first: allowIn=%b need 0001", ch_allowIn);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (htu_valid !== 1'b1 || htu_ch_id !== 2'd0 || htu_addr !== 32'h0000_0A00 ||
          htu_wbuf !== 8'h02 || ch_allowIn !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b ch=%0d addr=%h wbuf=%h allowIn=%b need 1 0 00000a00 02 0000",
                 i, htu_valid, htu_ch_id, htu_addr, htu_wbuf, ch_allowIn);
      end
      tick();
    end
    htu_allowIn = 1'b1;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0010) begin
      fails++;
      $display("FAIL bp_release: allowIn=%b need 0010", ch_allowIn);
    end
    tick();
    ch_valid = '0;
    #1;
    tests++;
    if (htu_valid !== 1'b1 || htu_ch_id !== 2'd1 || htu_addr !== 32'h0000_0B00 ||
        htu_wbuf !== 8'h0E || outstanding !== 4'd2) begin
      fails++;
      $display("FAIL bp_next: valid=%b ch=%0d addr=%h wbuf=%h outst=%0d need 1 1 00000b00 0e 2",
               htu_valid, htu_ch_id, htu_addr, htu_wbuf, outstanding);
    end
    $display("[TB] backpressure: next ch=%0d outst=%0d", htu_ch_id, outstanding);
  endtask

  task automatic test_credit();
    do_reset();
    ch_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++;
      if (ch_allowIn !== 4'b0001 || outstanding !== 4'(i)) begin
        fails++;
        $display("FAIL credit_grant[%0d]: allowIn=%b outst=%0d need 0001 %0d", i, ch_allowIn, outstanding, i);
      end
      tick();
    end
    #1;
    tests++;
    if (ch_allowIn !== 4'b0000 || outstanding !== 4'd8) begin
      fails++;
      $display("FAIL credit_full: allowIn=%b outst=%0d need 0000 8", ch_allowIn, outstanding);
    end
    htu_done = 1'b1;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0000) begin
      fails++;
      $display("FAIL credit_nobypass: allowIn=%b need 0000", ch_allowIn);
    end
    tick();
    htu_done = 1'b0;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0001 || outstanding !== 4'd7) begin
      fails++;
      $display("FAIL credit_regrant: allowIn=%b outst=%0d need 0001 7", ch_allowIn, outstanding);
    end
    tick();
    #1;
    tests++;
    if (ch_allowIn !== 4'b0000 || outstanding !== 4'd8) begin
      fails++;
      $display("FAIL credit_refill: allowIn=%b outst=%0d need 0000 8", ch_allowIn, outstanding);
    end
    $display("[TB] credit: outst=%0d allowIn=%b", outstanding, ch_allowIn);
    ch_valid = '0;
  endtask

  task automatic test_errors();
    do_reset();
    htu_done = 1'b1;
    tick();
    htu_done = 1'b0;
    #1;
    tests++;
    if (err !== 1'b1 || outstanding !== 4'd0) begin
      fails++;
      $display("FAIL err_done0: err=%b outst=%0d need 1 0", err, outstanding);
    end
    do_reset();
    #1;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err=%b need 0", err);
    end
    ch_valid[3] = 1'b1;
    ch_addr[3]  = 32'h0000_0010;
    ch_entry[3] = 3'd1;
    #1;
    tests++;
    if (ch_allowIn !== 4'b1000) begin
      fails++;
      $display("FAIL err_bank_grant: allowIn=%b need 1000", ch_allowIn);
    end
    tick();
    ch_valid = '0;
    #1;
    tests++;
    if (err !== 1'b1 || htu_valid !== 1'b1 || htu_ch_id !== 2'd3 ||
        htu_addr !== 32'h0000_0010 || htu_wbuf !== 8'h19) begin
      fails++;
      $display("FAIL err_bank: err=%b valid=%b ch=%0d addr=%h wbuf=%h need 1 1 3 00000010 19",
               err, htu_valid, htu_ch_id, htu_addr, htu_wbuf);
    end
    $display("[TB] errors: err=%b ch=%0d", err, htu_ch_id);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_valid   = 4'b0111;
    ch_addr[2] = 32'h0000_0020;
    repeat (3) tick();
    #1;
    tests++;
    if (htu_valid !== 1'b1 || outstanding !== 4'd3 || err !== 1'b1 || htu_ch_id !== 2'd2) begin
      fails++;
      $display("FAIL rstmid_pre: valid=%b outst=%0d err=%b ch=%0d need 1 3 1 2",
               htu_valid, outstanding, err, htu_ch_id);
    end
    ch_valid = 4'b1111;
    rst = 1'b1;
    #1;
    tests++;
    if (htu_valid !== 1'b0 || outstanding !== 4'd0 || err !== 1'b0 || ch_allowIn !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_now: valid=%b outst=%0d err=%b allowIn=%b need 0 0 0 0000",
               htu_valid, outstanding, err, ch_allowIn);
    end
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (ch_allowIn !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_ptr: allowIn=%b need 0001", ch_allowIn);
    end
    $display("[TB] reset_mid: allowIn after release=%b", ch_allowIn);
    ch_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_credit();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xbar_bank_arbiter.md
Name: xbar_bank_arbiter

Overview:
- Per-bank request arbiter inside the cross-bar core; one instance per bank (4 total).
- Shares a bank's HTU request port between the 4 channel buffers.
- Selects among channel buffer heads targeting this bank with round-robin priority and holds the winner in an output register until the HTU accepts it.
- Limits in-flight HTU requests with an outstanding counter released by bank completion pulses.

Parameters:
- NUM_CH, 4, number of channel buffers (fixed at 4; CH_W = 2).
- ENTRY_W, 3, channel buffer entry ID width.
- MAX_OUTSTANDING, 8, maximum requests issued to the bank and not yet completed (range 1..15).
- BANK_ID, 0, bank index; checked against addr[5:4].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ch_valid_i  in  4  channel i has a request for this bank
- ch_allowIn_o  out  4  grant to channel i; handshake = valid & allowIn
- ch_op_i  in  4x2  opcode per channel
- ch_addr_i  in  4x32  address per channel
- ch_data_i  in  4x128  write data per channel
- ch_entry_id_i  in  4xENTRY_W  buffer entry ID per channel
- htu_valid_o  out  1  request to bank HTU valid
- htu_allowIn_i  in  1  HTU ready
- htu_ch_id_o  out  2  winning channel
- htu_opcode_o  out  2  opcode
- htu_addr_o  out  32  address, bits [3:0] forced to 0
- htu_data_o  out  128  data
- htu_wbuffer_id_o  out  8  {3'b0, ch_id[1:0], entry_id[2:0]}
- htu_done_i  in  1  bank retired one request (single-cycle pulse)
- outstanding_o  out  4  current outstanding count
- err_o  out  1  sticky error flag

Behaviour:
- Reset values:
  - htu_valid_o = 0; all htu payload outputs = 0.
  - RR pointer = 0; outstanding = 0; err_o = 0.
  - ch_allowIn_o is combinational and evaluates to 0 during reset.
- Output register (REG) is free when !htu_valid_o or (htu_valid_o & htu_allowIn_i).
- can_issue = REG free & (outstanding < MAX_OUTSTANDING).
  - No same-cycle credit bypass: outstanding == MAX with htu_done_i high still blocks issue.
- Arbitration is combinational:
  - Scan from the RR pointer upward, mod 4; the first valid channel wins.
  - ch_allowIn_o = one-hot winner when can_issue, else 0.
  - At most one bit of ch_allowIn_o is ever set.
- On a grant:
  - REG loads the winner's payload next cycle; htu_valid_o = 1.
  - RR pointer = (winner + 1) mod 4.
- Latency: channel handshake in cycle N gives htu_valid_o in cycle N+1.
- Back-to-back: a drain and a new grant in the same cycle sustain 1 request/cycle.
- Hold rule: while htu_valid_o & !htu_allowIn_i, all htu outputs stay stable and no grant is issued.
- Outstanding counter:
  - +1 on grant; -1 on htu_done_i; both in the same cycle leave it unchanged.
  - htu_done_i with outstanding == 0: counter stays 0 and err_o is set.
- err_o is also set when a granted channel's addr[5:4] != BANK_ID. The request is still forwarded.
- err_o clears only on rst.
- No channel valid: no grant, pointer unchanged.
- Reset mid-transfer: REG and outstanding are dropped immediately; no HTU handshake completes while rst is high.
- A channel withdrawing valid without a grant is legal; the arbiter keeps no memory of it.

Decomposition:
- Shared package xbar_pkg:
  - NUM_CH, CH_W, ENTRY_W, WBUF_ID_W = 8, ADDR_W = 32, DATA_W = 128, OP_W = 2.
  - xbar_req_t struct {op, addr, data, entry_id}.
  - function make_wbuffer_id(ch, entry).
- One sub-module: xbar_rr_arb4, a combinational 4-way round-robin picker.
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: gnt[3:0], gnt_idx[1:0].
- The pointer register stays in the parent.

Test Plan:
- Single request: ch2 valid, op=1, addr=0x0000_1234, entry=5, htu_allowIn=1.
  - Required: ch_allowIn_o = 4'b0100 in cycle N; cycle N+1 htu_valid=1, ch_id=2, addr=0x0000_1230, wbuffer_id=8'h15.
  - Required: outstanding = 1.
- Fairness: all 4 channels valid continuously, htu_allowIn=1, pointer at 0.
  - Required: grant order 0,1,2,3,0,… at 1/cycle, each channel granted exactly 25 of 100 grants.
- Backpressure: htu_allowIn=0 for 5 cycles while ch0 and ch1 are valid.
  - Required: htu outputs stable for 5 cycles, ch_allowIn_o = 0.
  - Required: after release, REG drains and ch1 (pointer = 1) is granted in the same cycle.
- Credit limit: MAX_OUTSTANDING=8, no done pulses.
  - Required: exactly 8 grants, then ch_allowIn_o = 0 and outstanding = 8.
  - Required: a done pulse blocks that cycle; the next grant comes one cycle later; outstanding returns to 8.
- Errors: a done pulse at outstanding=0 sets err_o=1 and outstanding stays 0.
  - Required: on a fresh reset, a ch3 request with addr[5:4]=2'b01 on BANK_ID=0 sets err_o and is still forwarded.
- Reset mid-operation: assert rst while htu_valid=1 and outstanding=3.
  - Required: htu_valid_o, outstanding and err_o are all 0 immediately.
  - Required: the pointer restarts at ch0.
